// File: rtl/xorshift_prng_engine_pkg.sv
// Shared definitions for the xorshift PRNG engine: FSM state encoding,
// default shift triple and the default (non-zero) seed.
package xorshift_prng_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } xs_fsm_t;

  localparam int unsigned XS_WIDTH_DEFAULT = 16;
  localparam int unsigned XS_SH_A_DEFAULT  = 7;
  localparam int unsigned XS_SH_B_DEFAULT  = 9;
  localparam int unsigned XS_SH_C_DEFAULT  = 8;

  localparam logic [XS_WIDTH_DEFAULT-1:0] XS_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/xorshift_step.sv
// One xorshift iteration: x ^= x<<SH_A; x ^= x>>SH_B; x ^= x<<SH_C (mod 2^WIDTH).
// Purely combinational, reusable by other generators.
// Ports:
//   i_x    : current state word
//   o_fx_c : next state word f(i_x)
module xorshift_step #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SH_A  = 7,
  parameter int unsigned SH_B  = 9,
  parameter int unsigned SH_C  = 8
) (
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_fx_c
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;

  // Logical shifts with zero fill; bits shifted past WIDTH are dropped.
  assign w_a    = i_x ^ (i_x << SH_A);
  assign w_b    = w_a ^ (w_a >> SH_B);
  assign o_fx_c = w_b ^ (w_b << SH_C);

endmodule

// File: rtl/xorshift_prng_engine.sv
// Xorshift PRNG engine: seed register, step function, run counter, control
// FSM (IDLE/GEN/DONE) and a valid/ready output stream.
// Optional build macro XORSHIFT_WHITEN_EN: output word becomes f(x)+x
// (x = pre-step state); the state sequence itself is unchanged.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_seed_in     : seed value, loaded by i_seed_load in IDLE (zero -> SEED_DEFAULT)
//   i_count_in    : words to generate, latched by i_start in IDLE
//   o_busy        : FSM not in IDLE
//   o_rnd_out     : random word, o_out_valid/i_out_ready handshake
//   o_remaining   : words still to be accepted in the current run
//   o_done        : one-cycle pulse at end of run
module xorshift_prng_engine
  import xorshift_prng_engine_pkg::*;
#(
  parameter int unsigned         WIDTH        = XS_WIDTH_DEFAULT,
  parameter int unsigned         CNT_W        = 8,
  parameter int unsigned         SH_A         = XS_SH_A_DEFAULT,
  parameter int unsigned         SH_B         = XS_SH_B_DEFAULT,
  parameter int unsigned         SH_C         = XS_SH_C_DEFAULT,
  parameter logic [WIDTH-1:0]    SEED_DEFAULT = WIDTH'(XS_SEED_DEFAULT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_seed_load,
  input  logic [CNT_W-1:0] i_count_in,
  input  logic             i_start,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_rnd_out,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [CNT_W-1:0] o_remaining,
  output logic             o_done
);

  xs_fsm_t          r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_rnd;
  logic             r_valid;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_seed_guard;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_fx;
  logic [WIDTH-1:0] w_word;

  // A zero state would lock xorshift at zero forever.
  assign w_seed_guard = (i_seed_in == '0) ? SEED_DEFAULT : i_seed_in;

  // A simultaneous seed_load + start in IDLE must run from the new seed.
  assign w_x = ((r_fsm == ST_IDLE) && i_seed_load) ? w_seed_guard : r_state;

  xorshift_step #(
    .WIDTH (WIDTH),
    .SH_A  (SH_A),
    .SH_B  (SH_B),
    .SH_C  (SH_C)
  ) u_step (
    .i_x    (w_x),
    .o_fx_c (w_fx)
  );

`ifdef XORSHIFT_WHITEN_EN
  assign w_word = w_fx + w_x;
`else
  assign w_word = w_fx;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm       <= ST_IDLE;
      r_state     <= SEED_DEFAULT;
      r_rnd       <= '0;
      r_valid     <= 1'b0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (i_seed_load) begin
            r_state <= w_seed_guard;
          end
          if (i_start) begin
            r_remaining <= i_count_in;
            r_busy      <= 1'b1;
            if (i_count_in != '0) begin
              r_fsm   <= ST_GEN;
              r_rnd   <= w_word;
              r_valid <= 1'b1;
              r_state <= w_fx;
            end else begin
              r_fsm  <= ST_DONE;
              r_done <= 1'b1;
            end
          end
        end
        ST_GEN: begin
          if (r_valid && i_out_ready) begin
            if (r_remaining > CNT_W'(1)) begin
              r_remaining <= r_remaining - CNT_W'(1);
              r_rnd       <= w_word;
              r_state     <= w_fx;
            end else begin
              // Last word accepted: state is not advanced again, so the
              // next run continues the sequence from here.
              r_remaining <= '0;
              r_valid     <= 1'b0;
              r_fsm       <= ST_DONE;
              r_done      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_fsm  <= ST_IDLE;
          r_busy <= 1'b0;
        end
        default: begin
          r_fsm   <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_rnd_out   = r_rnd;
  assign o_out_valid = r_valid;
  assign o_remaining = r_remaining;
  assign o_done      = r_done;

endmodule

// File: tb/tb_xorshift_prng_engine.sv
// Self-checking bench for xorshift_prng_engine: randomized runs against a
// behavioural model of the generator sequence and handshake.
`timescale 1ns/1ps
module tb_xorshift_prng_engine;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] seed_in;
  logic             seed_load;
  logic [CNT_W-1:0] count_in;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] rnd_out;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] remaining;
  logic             done;

  int n_tests;
  int n_fail;

  logic [15:0] m_x;        // model generator state
  logic [15:0] first_word;

  xorshift_prng_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_seed_in   (seed_in),
    .i_seed_load (seed_load),
    .i_count_in  (count_in),
    .i_start     (start),
    .o_busy      (busy),
    .o_rnd_out   (rnd_out),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_remaining (remaining),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step function with arithmetic: left shift = multiply, right = divide.
  function automatic logic [15:0] mf(input logic [15:0] x);
    int unsigned v;
    v = x;
    v = (v ^ (v * 128)) % 65536;
    v = v ^ (v / 512);
    v = (v ^ (v * 256)) % 65536;
    return 16'(v);
  endfunction

  function automatic logic [15:0] mword(input logic [15:0] x);
`ifdef XORSHIFT_WHITEN_EN
    return 16'((int'(mf(x)) + int'(x)) % 65536);
`else
    return mf(x);
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rnd"},   32'(rnd_out),   32'd0);
    chk({tag, "_rem"},   32'(remaining), 32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
  endtask

  // One run. ready_pct: chance of out_ready per cycle; hold_first: cycles of
  // forced backpressure on the first word; noise: toggle seed_load/start
  // while busy (must be ignored).
  task automatic do_run(input bit load, input logic [15:0] seed, input int cnt,
                        input int ready_pct, input int hold_first, input bit noise);
    int left;
    int guard;
    int held;
    bit rdy;
    bit first;
    logic [15:0] exp;
    @(negedge clk);
    seed_load = load;
    seed_in   = seed;
    count_in  = CNT_W'(cnt);
    start     = 1'b1;
    if (load) m_x = (seed == 16'h0) ? 16'hACE1 : seed;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
    if (cnt == 0) begin
      chk("zc_busy",  32'(busy),      32'd1);
      chk("zc_done",  32'(done),      32'd1);
      chk("zc_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("zc_done_end", 32'(done),      32'd0);
      chk("zc_busy_end", 32'(busy),      32'd0);
      chk("zc_valid2",   32'(out_valid), 32'd0);
      return;
    end
    exp   = mword(m_x);
    m_x   = mf(m_x);
    left  = cnt;
    guard = 0;
    held  = 0;
    first = 1'b1;
    while (left > 0 && guard < 2000) begin
      chk("valid", 32'(out_valid), 32'd1);
      chk("rnd",   32'(rnd_out),   32'(exp));
      chk("rem",   32'(remaining), 32'(left));
      chk("done",  32'(done),      32'd0);
      chk("busy",  32'(busy),      32'd1);
      if (first) begin
        first_word = rnd_out;
        first      = 1'b0;
      end
      if (held < hold_first) begin
        rdy = 1'b0;
        held++;
      end else begin
        rdy = ($urandom_range(99) < 32'(ready_pct));
      end
      out_ready = rdy;
      if (noise) begin
        seed_load = 1'($urandom_range(1));
        seed_in   = 16'($urandom);
        start     = 1'($urandom_range(1));
        count_in  = CNT_W'($urandom_range(9));
      end
      @(negedge clk);
      if (rdy) begin
        left--;
        if (left > 0) begin
          exp = mword(m_x);
          m_x = mf(m_x);
        end
      end
      guard++;
    end
    out_ready = 1'b0;
    seed_load = 1'b0;
    start     = 1'b0;
    if (left > 0) chk("run_timeout", 32'(left), 32'd0);
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_done",  32'(done),      32'd1);
    chk("end_rem",   32'(remaining), 32'd0);
    chk("end_busy",  32'(busy),      32'd1);
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    seed_in   = '0;
    seed_load = 1'b0;
    count_in  = '0;
    start     = 1'b0;
    out_ready = 1'b0;
    m_x       = 16'hACE1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Known vector from seed 1.
    do_run(1'b1, 16'h0001, 2, 100, 0, 1'b0);
`ifdef XORSHIFT_WHITEN_EN
    chk("vec_seed1", 32'(first_word), 32'h8182);
`else
    chk("vec_seed1", 32'(first_word), 32'h8181);
`endif
    chk("vec_model_state", 32'(m_x), 32'h6021);

    // Zero seed falls back to the default seed.
    do_run(1'b1, 16'h0000, 1, 100, 0, 1'b0);
    chk("zero_seed_word", 32'(first_word), 32'(mword(16'hACE1)));

    // Backpressure on the first word, then full-rate accepts.
    do_run(1'b1, 16'($urandom) | 16'h1, 3, 100, 4, 1'b0);

    // Zero-length run.
    do_run(1'b0, 16'h0, 0, 100, 0, 1'b0);

    // Sequence continues across runs without reseeding.
    do_run(1'b0, 16'h0, 4, 100, 0, 1'b0);

    // Randomized runs with random backpressure and ignored inputs while busy.
    for (int r = 0; r < 8; r++) begin
      do_run(1'($urandom_range(1)), 16'($urandom), int'($urandom_range(1, 9)),
             int'($urandom_range(30, 100)), int'($urandom_range(2)), 1'b1);
    end

    // Reset mid-run: asynchronous return to reset values, no done pulse.
    @(negedge clk);
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    count_in  = CNT_W'(5);
    start     = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
    chk("mid_rem_before", 32'(remaining), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    m_x = 16'hACE1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    do_run(1'b0, 16'h0, 3, 100, 0, 1'b0);
    chk("after_rst_word", 32'(first_word), 32'(mword(16'hACE1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xorshift_prng_engine.md
Name: xorshift_prng_engine

Overview:
- Parametrised xorshift pseudo-random number generator: seed register, three-stage shift/XOR step, and a down-counter that sets how many values to produce.
- Adds a control FSM, a valid/ready output handshake, a zero-seed guard and completion signalling on top of the 16-bit seed/counter datapath.
- Sits between a host that writes seed and count, and any stream consumer of random words.

Parameters:
- WIDTH, 16, state and output word width (>=8).
- CNT_W, 8, width of the iteration counter.
- SH_A, 7, first left-shift amount (1..WIDTH-1).
- SH_B, 9, right-shift amount (1..WIDTH-1).
- SH_C, 8, second left-shift amount (1..WIDTH-1).
- SEED_DEFAULT, 16'hACE1, non-zero seed used at reset and in place of a zero seed (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- seed_in  in  WIDTH  seed value.
- seed_load  in  1  load seed_in into state (IDLE only).
- count_in  in  CNT_W  number of words to generate.
- start  in  1  begin a run (IDLE only).
- busy  out  1  high whenever FSM is not IDLE.
- rnd_out  out  WIDTH  random word.
- out_valid  out  1  rnd_out holds a valid word.
- out_ready  in  1  consumer accepts the word.
- remaining  out  CNT_W  words still to be accepted in the current run.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: state=SEED_DEFAULT, FSM=IDLE, remaining=0, rnd_out=0, out_valid=0, busy=0, done=0.
- Step function f(x), all mod 2^WIDTH: x^=x<<SH_A; x^=x>>SH_B; x^=x<<SH_C. Logical shifts, zero fill.
- Zero-seed guard: seed_load with seed_in==0 loads SEED_DEFAULT.
- FSM states are IDLE, GEN and DONE.
- IDLE:
  - seed_load updates state.
  - start latches count_in into remaining.
  - start with count_in!=0 -> GEN; rnd_out=f(state) and out_valid=1 from the next cycle; state<=f(state).
  - start with count_in==0 -> DONE directly; no words produced.
  - seed_load and start in the same cycle: the run uses the newly loaded (guarded) seed.
- GEN:
  - rnd_out and out_valid are held stable until out_ready.
  - Accept (out_valid&&out_ready) with remaining>1: remaining-=1, the next word is presented the following cycle (throughput 1 word/cycle), state advances.
  - Accept with remaining==1: remaining=0, out_valid=0 the next cycle, -> DONE.
  - seed_load and start are ignored while busy.
- DONE: done=1 for exactly one cycle, busy=1, then -> IDLE. State is retained, so the next run continues the sequence.
- rst asserted mid-run: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro: XORSHIFT_WHITEN_EN.
- Defined: rnd_out = f(x) + x (mod 2^WIDTH), where x is the pre-step state; the adder output whitens the word. The state sequence is unchanged.
- Undefined: rnd_out = f(x); no adder is instantiated.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, GEN, DONE).
  - Default shift triple (7,9,8).
  - SEED_DEFAULT constant.
- One combinational sub-module, xorshift_step, is natural: parametrised by WIDTH/SH_A/SH_B/SH_C, input x, output f(x). It is reusable by other generators.

Test Plan:
- Reset, then seed_load 16'h0001, start count 2, out_ready=1 -> rnd_out 16'h8181 then 16'h6021 on consecutive cycles, remaining 2->1->0, done pulse one cycle after the second accept.
- Same as above with XORSHIFT_WHITEN_EN defined -> first rnd_out 16'h8182 (16'h8181+16'h0001).
- seed_load 16'h0000 -> state becomes 16'hACE1; start count 1 gives rnd_out = f(16'hACE1) as computed by the reference model.
- Backpressure: count 3, out_ready low for 4 cycles on word 1 -> rnd_out and out_valid stable, remaining stays 3; then 3 accepts produce the reference sequence with no loss or duplication.
- start with count_in 0 -> no out_valid, busy high 1 cycle, done pulse 1 cycle after start.
- rst pulsed mid-run (remaining 5) -> all outputs return to reset values asynchronously, no done pulse; a new run after reset starts from SEED_DEFAULT.
